alu_issue_ctrl: RTL and testbench

Sequential initiator for the 32-bit combinational ALU (4-bit op select, `inA`/`inB`, `result`/`zero`, `changeROM`/`NextLineTBE` gating). It accepts operation requests over a valid/ready handshake and drives and holds the ALU inputs for an op-dependent number of settle cycles. It then captures `result`/`zero` and returns them over a valid/ready response channel. Divide-by-zero and illegal opcodes are resolved locally without exercising the ALU. It sits between the datapath control and the ALU, so slow combinational div/mult paths get multicycle timing.

---
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - Multicycle issue controller for the combinational ALU
// Holds ALU operands for an op-dependent settle time, then returns result/zero with the request tag.
module alu_issue_ctrl #(
    parameter int BASE_WAIT = 1,
    parameter int MUL_WAIT  = 2,
    parameter int DIV_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_tag,
    output logic [3:0]  ALU_Control,
    output logic [31:0] inA,
    output logic [31:0] inB,
    output logic        changeROM,
    output logic [1:0]  NextLineTBE,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic [4:0]  rsp_tag,
    output logic        rsp_divzero,
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [7:0]  cnt;
    logic        accept;
    logic        div0;
    logic        illegal;

    // Counter is loaded with WAIT-1 so the capture edge lands exactly WAIT edges after accept.
    function automatic logic [7:0] wait_load(input logic [3:0] op);
        case (op)
            4'b0000: return 8'(DIV_WAIT - 1);
            4'b0001: return 8'(MUL_WAIT - 1);
            default: return 8'(BASE_WAIT - 1);
        endcase
    endfunction

    assign accept  = (state == IDLE) && !flush && req_valid;
    assign div0    = (req_op == 4'b0000) && (req_b == 32'd0);
    assign illegal = (req_op[3:2] == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush;
                if (accept) begin
                    state_nxt = (div0 || illegal) ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 8'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Locally resolved ops fill the payload at accept; ALU ops overwrite it at the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 4'b0011;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            cnt         <= 8'd0;
            rsp_result  <= 32'd0;
            rsp_zero    <= 1'b0;
            rsp_tag     <= 5'd0;
            rsp_divzero <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (accept) begin
            op_q        <= req_op;
            a_q         <= req_a;
            b_q         <= req_b;
            cnt         <= wait_load(req_op);
            rsp_tag     <= req_tag;
            rsp_result  <= div0 ? 32'hFFFF_FFFF : 32'd0;
            rsp_zero    <= illegal;
            rsp_divzero <= div0 && !illegal;
            rsp_illegal <= illegal;
        end else if (state == EXEC) begin
            if (cnt == 8'd0) begin
                rsp_result  <= alu_result;
                rsp_zero    <= alu_zero;
                rsp_divzero <= 1'b0;
                rsp_illegal <= 1'b0;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    assign changeROM   = (state != EXEC);
    assign ALU_Control = (state == EXEC) ? op_q : 4'b0011;
    assign inA         = (state == EXEC) ? a_q : 32'd0;
    assign inB         = (state == EXEC) ? b_q : 32'd0;
    assign NextLineTBE = 2'b00;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - Self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    localparam int BW = 1;
    localparam int MW = 2;
    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;
    logic [3:0]  ALU_Control;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        changeROM;
    logic [1:0]  NextLineTBE;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [4:0]  rsp_tag;
    logic        rsp_divzero;
    logic        rsp_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        zero;
        logic        dz;
        logic        il;
        int          lat;
    } vec_t;

    alu_issue_ctrl #(.BASE_WAIT(BW), .MUL_WAIT(MW), .DIV_WAIT(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .ALU_Control(ALU_Control), .inA(inA), .inB(inB),
        .changeROM(changeROM), .NextLineTBE(NextLineTBE),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .rsp_divzero(rsp_divzero), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU attached to the controller.
    always_comb begin
        alu_result = 32'd0;
        if (!changeROM) begin
            case (ALU_Control)
                4'd0:  alu_result = (inB == 0) ? 32'd0 : inA / inB;
                4'd1:  alu_result = inA * inB;
                4'd2:  alu_result = inA - inB;
                4'd3:  alu_result = inA + inB;
                4'd4:  alu_result = inA | inB;
                4'd5:  alu_result = inA & inB;
                4'd6:  alu_result = ($signed(inA) <  $signed(inB)) ? 32'd1 : 32'd0;
                4'd7:  alu_result = ($signed(inA) <= $signed(inB)) ? 32'd1 : 32'd0;
                4'd8:  alu_result = ($signed(inA) >  $signed(inB)) ? 32'd1 : 32'd0;
                4'd9:  alu_result = ($signed(inA) >= $signed(inB)) ? 32'd1 : 32'd0;
                4'd10: alu_result = (inA == inB) ? 32'd1 : 32'd0;
                4'd11: alu_result = (inA != inB) ? 32'd1 : 32'd0;
                default: alu_result = 32'd0;
            endcase
        end
        alu_zero = (alu_result == 32'd0);
    end

    function automatic vec_t ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] tag);
        vec_t v;
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        v.op = op; v.a = a; v.b = b; v.tag = tag;
        v.dz = 1'b0; v.il = 1'b0;
        v.lat = (op == 4'd0) ? DW : (op == 4'd1) ? MW : BW;
        if (op >= 4'd12) begin
            v.res = 32'd0; v.il = 1'b1; v.lat = 0;
        end else if (op == 4'd0 && b == 0) begin
            v.res = 32'hFFFF_FFFF; v.dz = 1'b1; v.lat = 0;
        end else begin
            case (op)
                4'd0:  v.res = a / b;
                4'd1:  v.res = a * b;
                4'd2:  v.res = a - b;
                4'd3:  v.res = a + b;
                4'd4:  v.res = a | b;
                4'd5:  v.res = a & b;
                4'd6:  v.res = 32'(sa <  sb);
                4'd7:  v.res = 32'(sa <= sb);
                4'd8:  v.res = 32'(sa >  sb);
                4'd9:  v.res = 32'(sa >= sb);
                4'd10: v.res = 32'(a == b);
                default: v.res = 32'(a != b);
            endcase
        end
        v.zero = v.il ? 1'b1 : (v.dz ? 1'b0 : (v.res == 32'd0));
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Starts at the negedge after the accept edge; finishes after the response handshake.
    task automatic collect(input vec_t v, input int hold);
        int  k = 0;
        int  low = 0;
        bit  held = 1'b1;
        while (!rsp_valid && k < 300) begin
            if (!changeROM) begin
                low++;
                if (ALU_Control !== v.op || inA !== v.a || inB !== v.b) held = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        check("rsp_latency", 32'(k), 32'(v.lat));
        check("exec_cycles", 32'(low), 32'(v.lat));
        check("alu_drive_held", 32'(held), 32'd1);
        for (int i = 0; i < hold; i++) @(negedge clk);
        check("rsp_valid_held", 32'(rsp_valid), 32'd1);
        check("rsp_result", rsp_result, v.res);
        check("rsp_zero", 32'(rsp_zero), 32'(v.zero));
        check("rsp_tag", 32'(rsp_tag), 32'(v.tag));
        check("rsp_divzero", 32'(rsp_divzero), 32'(v.dz));
        check("rsp_illegal", 32'(rsp_illegal), 32'(v.il));
        check("resp_gated", 32'(changeROM), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        issue(v.op, v.a, v.b, v.tag);
        collect(v, hold);
    endtask

    task automatic check_idle(input string name);
        check({name, "_changeROM"}, 32'(changeROM), 32'd1);
        check({name, "_ALU_Control"}, 32'(ALU_Control), 32'd3);
        check({name, "_inA"}, inA, 32'd0);
        check({name, "_inB"}, inB, 32'd0);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'd3,  32'd5,   32'd7,   5'd3,  32'd12,         1'b0, 1'b0, 1'b0, BW};
        vecs[1] = '{4'd0,  32'd100, 32'd7,   5'd4,  32'd14,         1'b0, 1'b0, 1'b0, DW};
        vecs[2] = '{4'd0,  32'd9,   32'd0,   5'd5,  32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{4'd13, 32'd1,   32'd2,   5'd6,  32'd0,          1'b1, 1'b0, 1'b1, 0};
        vecs[4] = '{4'd10, 32'd42,  32'd42,  5'd7,  32'd1,          1'b0, 1'b0, 1'b0, BW};
        vecs[5] = '{4'd1,  32'd6,   32'd7,   5'd8,  32'd42,         1'b0, 1'b0, 1'b0, MW};
        vecs[6] = '{4'd6,  32'hFFFF_FFFF, 32'd1, 5'd9, 32'd1,       1'b0, 1'b0, 1'b0, BW};
        vecs[7] = '{4'd11, 32'd5,   32'd5,   5'd10, 32'd0,          1'b1, 1'b0, 1'b0, BW};

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 4'd0; req_a = 32'd0; req_b = 32'd0; req_tag = 5'd0;
        #3;
        check_idle("reset");
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_NextLineTBE", 32'(NextLineTBE), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        check("reset_rsp_flags", {29'd0, rsp_zero, rsp_divzero, rsp_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i % 3);

        // Backpressure: response held while a new request waits.
        begin
            int k = 0;
            issue(4'd2, 32'd3, 32'd3, 5'd12);
            while (!rsp_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            req_valid = 1'b1; req_op = 4'd3; req_a = 32'd1; req_b = 32'd2; req_tag = 5'd13;
            for (int i = 0; i < 3; i++) begin
                check("bp_req_ready", 32'(req_ready), 32'd0);
                check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                check("bp_rsp_result", rsp_result, 32'd0);
                check("bp_rsp_zero", 32'(rsp_zero), 32'd1);
                check("bp_rsp_tag", 32'(rsp_tag), 32'd12);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("bp_rsp_done", 32'(rsp_valid), 32'd0);
            check("bp_not_accepted_on_handshake", 32'(req_ready), 32'd1);
            @(negedge clk);
            req_valid = 1'b0;
            collect(ref_model(4'd3, 32'd1, 32'd2, 5'd13), 0);
        end

        // Flush in the second EXEC cycle of a mult.
        begin
            bit quiet = 1'b1;
            issue(4'd1, 32'd3, 32'd4, 5'd11);
            @(negedge clk);
            check("flush_in_exec", 32'(changeROM), 32'd0);
            flush = 1'b1;
            @(negedge clk);
            check("flush_req_ready", 32'(req_ready), 32'd0);
            flush = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (rsp_valid) quiet = 1'b0;
                @(negedge clk);
            end
            check("flush_no_rsp", 32'(quiet), 32'd1);
            check_idle("flush");
            run_vec(ref_model(4'd3, 32'd1, 32'd1, 5'd16), 0);
        end

        // Asynchronous reset mid-EXEC of a div.
        begin
            bit quiet = 1'b1;
            issue(4'd0, 32'd50, 32'd5, 5'd14);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_idle("arst");
            check("arst_req_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (rsp_valid) quiet = 1'b0;
                @(negedge clk);
            end
            check("arst_no_rsp", 32'(quiet), 32'd1);
            run_vec(ref_model(4'd3, 32'd1, 32'd1, 5'd15), 0);
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : ((op == 4'd0) ? $urandom_range(1, 1000) : $urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            run_vec(ref_model(op, a, b, 5'($urandom_range(0, 31))), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
